// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button colour-index front end.
// FSM state encoding, counter widths and default parameter values.
package btn_pkg;

    localparam int COUNT_W        = 3;
    localparam int MS_CNT_W       = 8;
    localparam int DEF_LOCKOUT_MS = 200;
    localparam int DEF_NUM_STATES = 6;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        LOCKOUT      = 2'd1,
        WAIT_RELEASE = 2'd2
    } btn_state_e;

    // Modulo-n increment; n is at most 8 so the index never exceeds COUNT_W bits.
    function automatic logic [COUNT_W-1:0] next_index(input logic [COUNT_W-1:0] cur,
                                                       input int unsigned        n);
        logic [COUNT_W-1:0] nxt;
        nxt = (32'(cur) == n - 1) ? '0 : cur + 1'b1;
        return nxt;
    endfunction

endpackage

// File: rtl/btn_cycle_counter_if.sv
// Button-to-pixel-stage bundle: raw button in, colour index, press strobe and busy out.
// master drives the button; slave is the counter that answers with the index.
interface btn_cycle_counter_if;
    import btn_pkg::*;

    logic               button;
    logic [COUNT_W-1:0] count;
    logic               press;
    logic               busy;

    modport master (output button, input count, input press, input busy);
    modport slave  (input button, output count, output press, output busy);

endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every DIV enabled cycles, sync clear wins over enable.
// Tick is combinational from the count, so it lines up with the last cycle of each period.
module ms_tick_gen #(
    parameter int DIV = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] presc;

    assign tick = en && !clr && (presc == PW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (clr) begin
            presc <= '0;
        end else if (en) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

endmodule

// File: rtl/btn_cycle_counter.sv
// Debounced button: 2-flop sync, fixed ms lockout, modulo-NUM_STATES index bumped once per press.
// BTN_AUTO_REPEAT_EN: a held button re-triggers once per lockout period instead of parking.
module btn_cycle_counter
    import btn_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int LOCKOUT_MS = DEF_LOCKOUT_MS,
    parameter int NUM_STATES = DEF_NUM_STATES
) (
    input  logic               CLK,
    input  logic               RSTn,
    btn_cycle_counter_if.slave bus
);

    localparam int TICK_DIV = CLK_HZ / 1000;

    localparam logic [1:0] S_IDLE    = 2'(IDLE);
    localparam logic [1:0] S_LOCKOUT = 2'(LOCKOUT);
    localparam logic [1:0] S_WAIT    = 2'(WAIT_RELEASE);

    if ((CLK_HZ < 1000) || ((CLK_HZ % 1000) != 0)) begin : g_bad_clk_hz
        $error("CLK_HZ must be a positive multiple of 1000");
    end
    if ((LOCKOUT_MS < 1) || (LOCKOUT_MS > 255)) begin : g_bad_lockout
        $error("LOCKOUT_MS must be within 1..255");
    end
    if ((NUM_STATES < 2) || (NUM_STATES > 8)) begin : g_bad_states
        $error("NUM_STATES must be within 2..8");
    end

    logic                sync_0;
    logic                btn_s;
    logic [1:0]          state;
    logic [COUNT_W-1:0]  count_q;
    logic                press_q;
    logic [MS_CNT_W-1:0] ms_cnt;
    logic                ms_clr;
    logic                ms_en;
    logic                ms_tick;
    logic                lockout_done;

    assign ms_clr       = (state == S_IDLE) && btn_s;
    assign ms_en        = (state == S_LOCKOUT);
    assign lockout_done = ms_tick && (ms_cnt == MS_CNT_W'(LOCKOUT_MS - 1));

    ms_tick_gen #(
        .DIV (TICK_DIV)
    ) u_ms_tick_gen (
        .clk   (CLK),
        .rst_n (RSTn),
        .clr   (ms_clr),
        .en    (ms_en),
        .tick  (ms_tick)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync_0  <= 1'b0;
            btn_s   <= 1'b0;
            state   <= S_IDLE;
            count_q <= '0;
            press_q <= 1'b0;
            ms_cnt  <= '0;
        end else begin
            sync_0  <= bus.button;
            btn_s   <= sync_0;
            press_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (btn_s) begin
                        count_q <= next_index(count_q, NUM_STATES);
                        press_q <= 1'b1;
                        ms_cnt  <= '0;
                        state   <= S_LOCKOUT;
                    end
                end

                S_LOCKOUT: begin
                    if (ms_tick) begin
                        ms_cnt <= ms_cnt + 1'b1;
                    end
                    if (lockout_done) begin
`ifdef BTN_AUTO_REPEAT_EN
                        // Repeat goes back through IDLE, which re-accepts a held button next cycle.
                        state <= S_IDLE;
`else
                        state <= btn_s ? S_WAIT : S_IDLE;
`endif
                    end
                end

                S_WAIT: begin
                    if (!btn_s) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.count = count_q;
    assign bus.press = press_q;
    assign bus.busy  = (state != S_IDLE);

endmodule

// File: tb/tb_btn_cycle_counter.sv
// Randomised scoreboard bench for btn_cycle_counter against an edge-timeline model of accepted presses.
module tb_btn_cycle_counter;

    localparam int CLK_HZ   = 10_000;
    localparam int LOCK_MS  = 4;
    localparam int NS       = 6;
    localparam int LOCK_CYC = LOCK_MS * CLK_HZ / 1000;
`ifdef BTN_AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;

    always #5 CLK = ~CLK;

    btn_cycle_counter_if bus ();

    btn_cycle_counter #(
        .CLK_HZ     (CLK_HZ),
        .LOCKOUT_MS (LOCK_MS),
        .NUM_STATES (NS)
    ) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int edge_n;
        int cnt;
    } exp_t;

    exp_t q[$];
    bit   hist[$];
    int   cur_edge = -1;
    bit   has_last = 1'b0;
    int   last_acc = 0;
    int   m_count  = 0;
    bit   m_busy   = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Synchronised button seen by the FSM at edge u is the raw sample taken at edge u-2.
    function automatic bit zero_between(input int a, input int b);
        for (int u = a; u <= b; u++) begin
            if (u < 2) return 1'b1;
            if (hist[u-2] == 1'b0) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge CLK or negedge RSTn) begin : model
        int t;
        bit bs;
        bit acc;
        if (!RSTn) begin
            hist.delete();
            q.delete();
            cur_edge = -1;
            has_last = 1'b0;
            last_acc = 0;
            m_count  = 0;
            m_busy   = 1'b0;
        end else begin
            cur_edge++;
            t = cur_edge;
            hist.push_back(bus.button);
            bs  = (t >= 2) ? hist[t-2] : 1'b0;
            acc = 1'b0;
            if (bs) begin
                if (!has_last)
                    acc = 1'b1;
                else if (t >= last_acc + LOCK_CYC + 1)
                    acc = AUTO || zero_between(last_acc + LOCK_CYC, t - 1);
            end
            if (acc) begin
                m_count  = (m_count + 1) % NS;
                last_acc = t;
                has_last = 1'b1;
                m_busy   = 1'b1;
                q.push_back('{edge_n: t, cnt: m_count});
            end else if (!has_last) begin
                m_busy = 1'b0;
            end else if (t < last_acc + LOCK_CYC) begin
                m_busy = 1'b1;
            end else begin
                m_busy = !AUTO && !zero_between(last_acc + LOCK_CYC, t);
            end
        end
    end

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (!RSTn) begin
            chk("reset_count", int'(bus.count), 0);
            chk("reset_press", int'(bus.press), 0);
            chk("reset_busy", int'(bus.busy), 0);
        end else begin
            chk("count", int'(bus.count), m_count);
            chk("busy", int'(bus.busy), int'(m_busy));
            if (bus.press) begin
                if (q.size() == 0) begin
                    chk("press_unexpected", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("press_edge", cur_edge, e.edge_n);
                    chk("press_count", int'(bus.count), e.cnt);
                end
            end else if (q.size() > 0 && q[0].edge_n <= cur_edge) begin
                e = q.pop_front();
                chk("press_missed", 0, 1);
            end
        end
    end

    task automatic drive(input bit b, input int n);
        for (int i = 0; i < n; i++) begin
            bus.button = b;
            @(posedge CLK);
            #2;
        end
    endtask

    initial begin
        int base;
        bus.button = 1'b0;
        repeat (3) @(posedge CLK);
        #2 RSTn = 1'b1;

        drive(1'b0, 100);
        chk("idle_count", int'(bus.count), 0);

        drive(1'b1, 2);
        chk("pre_latency", int'(bus.count), 0);
        drive(1'b1, 1);
        chk("clean_press", int'(bus.count), 1);
        drive(1'b1, 57);
        drive(1'b0, 80);

        for (int k = 0; k < 6; k++) drive(bus.button ^ 1'b1 ? (k % 2 == 0) : (k % 2 == 0), 3);
        drive(1'b1, 20);
        drive(1'b0, 80);

        base = m_count;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 10);
            drive(1'b0, 50);
            chk("six_seq", int'(bus.count), (base + k + 1) % NS);
        end

        base = m_count;
        drive(1'b1, 200);
        drive(1'b0, 100);
        chk("hold_200", int'(bus.count), (base + (AUTO ? 5 : 1)) % NS);

        drive(1'b1, 22);
        RSTn = 1'b0;
        drive(1'b1, 3);
        RSTn = 1'b1;
        drive(1'b1, 2);
        chk("rst_pre_repress", int'(bus.count), 0);
        drive(1'b1, 1);
        chk("rst_repress", int'(bus.count), 1);
        drive(1'b1, 60);
        drive(1'b0, 80);

        repeat (20) drive(1'($urandom_range(0, 1)), $urandom_range(1, 60));
        drive(1'b0, 100);

        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
